// File: rtl/sample_frame_collector.sv
// Sample frame collector: packs a valid/ready sample stream into a parallel
// frame (data + slot enable mask) for a multi-input adder tree, and emits a
// sum_valid strobe aligned to the adder's pipeline latency.
//
// state | meaning
// FILL  | accepting samples into slots, s_ready high
// HOLD  | complete frame presented, waiting for pipe_ena to transfer it
module sample_frame_collector #(
  parameter int NUM_INPUT    = 8,
  parameter int WIDTH_IN     = 16,
  parameter int OUTPUT_DELAY = 1,
  parameter int LEN_W        = $clog2(NUM_INPUT + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [WIDTH_IN-1:0]                 s_data,
  input  logic                                s_last,
  input  logic                                pipe_ena,
  output logic                                frame_valid,
  output logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  frame_data,
  output logic [NUM_INPUT-1:0]                frame_enable,
  output logic [LEN_W-1:0]                    frame_len,
  output logic                                sum_valid
);

  localparam int IDX_W = $clog2(NUM_INPUT);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic             accept;
  logic             close_frame;
  logic             xfer;
  logic             last_slot;

  // State register; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode. s_ready is gated by rst_n so the
  // upstream sees no acceptance while reset is held.
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    frame_valid = 1'b0;
    accept      = 1'b0;
    close_frame = 1'b0;
    xfer        = 1'b0;
    last_slot   = (wr_idx == IDX_W'(NUM_INPUT - 1));
    case (state)
      FILL: begin
        s_ready     = rst_n;
        accept      = s_valid && rst_n;
        close_frame = accept && (last_slot || s_last);
        if (close_frame) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        frame_valid = 1'b1;
        xfer        = pipe_ena;
        if (xfer) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Frame buffer: slots fill in order; a transfer wipes data and mask so
  // unfilled slots always read zero with their enable bit low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx       <= '0;
      frame_data   <= '0;
      frame_enable <= '0;
      frame_len    <= '0;
    end else if (xfer) begin
      wr_idx       <= '0;
      frame_data   <= '0;
      frame_enable <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_INPUT; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          frame_data[i]   <= s_data;
          frame_enable[i] <= 1'b1;
        end
      end
      wr_idx <= wr_idx + IDX_W'(1);
      if (close_frame) begin
        frame_len <= LEN_W'(wr_idx) + LEN_W'(1);
      end
    end
  end

  generate
    if (OUTPUT_DELAY == 0) begin : g_comb_sum
      // Combinational adder: its output is valid in the transfer cycle itself.
      assign sum_valid = xfer;
    end else begin : g_pipe_sum
      logic [OUTPUT_DELAY-1:0] dly;

      // Valid token pipeline mirroring the adder; frozen with it on pipe_ena low.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly <= '0;
        end else if (pipe_ena) begin
          dly <= (dly << 1) | OUTPUT_DELAY'(xfer);
        end
      end

      assign sum_valid = dly[OUTPUT_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_sample_frame_collector.sv
// Bench for sample_frame_collector: three instances (OUTPUT_DELAY 0, 1, 3)
// share one stimulus stream and are checked every cycle against a
// queue-based frame model plus a list of in-flight transfer ages.
module tb_sample_frame_collector;

  localparam int NI = 8;
  localparam int W  = 16;
  localparam int LW = $clog2(NI + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic pipe_ena = 1'b0;
  logic [W-1:0] s_data = '0;

  logic                  s_ready_a [3];
  logic                  fv_a      [3];
  logic                  sv_a      [3];
  logic [NI-1:0][W-1:0]  fd_a      [3];
  logic [NI-1:0]         fe_a      [3];
  logic [LW-1:0]         fl_a      [3];

  always #5 clk = ~clk;

  sample_frame_collector #(.NUM_INPUT(NI), .WIDTH_IN(W), .OUTPUT_DELAY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a[0]),
    .s_data(s_data), .s_last(s_last), .pipe_ena(pipe_ena),
    .frame_valid(fv_a[0]), .frame_data(fd_a[0]), .frame_enable(fe_a[0]),
    .frame_len(fl_a[0]), .sum_valid(sv_a[0]));

  sample_frame_collector #(.NUM_INPUT(NI), .WIDTH_IN(W), .OUTPUT_DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a[1]),
    .s_data(s_data), .s_last(s_last), .pipe_ena(pipe_ena),
    .frame_valid(fv_a[1]), .frame_data(fd_a[1]), .frame_enable(fe_a[1]),
    .frame_len(fl_a[1]), .sum_valid(sv_a[1]));

  sample_frame_collector #(.NUM_INPUT(NI), .WIDTH_IN(W), .OUTPUT_DELAY(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a[2]),
    .s_data(s_data), .s_last(s_last), .pipe_ena(pipe_ena),
    .frame_valid(fv_a[2]), .frame_data(fd_a[2]), .frame_enable(fe_a[2]),
    .frame_len(fl_a[2]), .sum_valid(sv_a[2]));

  // Reference model: samples of the frame being built, whether it is held,
  // its latched length, and the pipe_ena-qualified age of every transfer.
  bit           m_hold = 1'b0;
  logic [W-1:0] m_q[$];
  int           m_len = 0;
  int           m_age[$];

  int errors = 0;
  int checks = 0;

  function automatic int dl(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic bit exp_sv(input int d);
    if (d == 0) return rst_n && m_hold && pipe_ena;
    foreach (m_age[i]) if (m_age[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NI-1:0][W-1:0] ed;
    logic [NI-1:0]        ee;
    ed = '0;
    ee = '0;
    for (int i = 0; i < m_q.size(); i++) begin
      ed[i] = m_q[i];
      ee[i] = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s_ready_d%0d", dl(k)), s_ready_a[k], rst_n && !m_hold);
      chk($sformatf("frame_valid_d%0d", dl(k)), fv_a[k], m_hold);
      chk($sformatf("frame_data_d%0d", dl(k)), fd_a[k], ed);
      chk($sformatf("frame_enable_d%0d", dl(k)), fe_a[k], ee);
      chk($sformatf("frame_len_d%0d", dl(k)), fl_a[k], m_len);
      chk($sformatf("sum_valid_d%0d", dl(k)), sv_a[k], exp_sv(dl(k)));
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit l, input bit pe);
    @(negedge clk);
    s_valid  = v;
    s_data   = d;
    s_last   = l;
    pipe_ena = pe;
    #1 compare_all();
  endtask

  task automatic step();
    bit xfer;
    @(posedge clk);
    if (rst_n) begin
      xfer = m_hold && pipe_ena;
      if (pipe_ena) begin
        foreach (m_age[i]) m_age[i]++;
        while (m_age.size() > 0 && m_age[0] > 3) void'(m_age.pop_front());
      end
      if (xfer) begin
        m_age.push_back(1);
        m_hold = 1'b0;
        m_q.delete();
      end else if (!m_hold && s_valid) begin
        m_q.push_back(s_data);
        if (m_q.size() == NI || s_last) begin
          m_hold = 1'b1;
          m_len  = m_q.size();
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] d, input bit l, input bit pe);
    drive(v, d, l, pe);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_hold  = 1'b0;
    m_q.delete();
    m_age.delete();
    m_len   = 0;
    #1 compare_all();
    chk("reset_s_ready", s_ready_a[1], 1'b0);
    chk("reset_enable", fe_a[1], '0);
    @(negedge clk);
    #1 compare_all();
    rst_n = 1'b1;
    step();
  endtask

  function automatic int slot_sum(input logic [NI-1:0][W-1:0] fd, input logic [NI-1:0] fe);
    int s = 0;
    for (int i = 0; i < NI; i++) if (fe[i]) s += int'($signed(fd[i]));
    return s;
  endfunction

  initial begin
    logic [NI-1:0][W-1:0] seq_frame;
    for (int i = 0; i < NI; i++) seq_frame[i] = W'(i + 1);

    // Reset state
    #2 compare_all();
    chk("reset_len", fl_a[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", s_ready_a[1], 1'b1);
    step();

    // Full frame 1..8 back-to-back
    for (int i = 0; i < NI; i++) cycle(1'b1, W'(i + 1), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("full_enable", fe_a[1], 8'hFF);
    chk("full_len", fl_a[1], 8);
    chk("full_sum", slot_sum(fd_a[1], fe_a[1]), 36);
    chk("full_d0_sum_valid", sv_a[0], 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("full_d1_sum_valid", sv_a[1], 1'b1);
    chk("full_frame_valid_drop", fv_a[1], 1'b0);
    step();

    // Short signed frame 5, -3, 7
    cycle(1'b1, 16'd5, 1'b0, 1'b1);
    cycle(1'b1, 16'hFFFD, 1'b0, 1'b1);
    cycle(1'b1, 16'd7, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("short_enable", fe_a[1], 8'h07);
    chk("short_len", fl_a[1], 3);
    chk("short_upper_zero", fd_a[1][NI-1:3], '0);
    chk("short_sum", slot_sum(fd_a[1], fe_a[1]), 9);
    step();

    // Stall in HOLD with s_valid offered
    for (int i = 0; i < NI; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
      chk("stall_ready", s_ready_a[1], 1'b0);
      chk("stall_sum_valid", sv_a[0] | sv_a[1] | sv_a[2], 1'b0);
      step();
    end
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Bubbles: s_valid alternates over 8 samples
    for (int i = 0; i < 2 * NI - 1; i++) begin
      if (i % 2 == 0) cycle(1'b1, W'(i / 2 + 1), 1'b0, 1'b1);
      else            cycle(1'b0, 16'h5555, 1'b0, 1'b1);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("bubble_frame", fd_a[1], seq_frame);
    chk("bubble_enable", fe_a[1], 8'hFF);
    step();

    // Reset after 4 of 8 samples
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(i + 100), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < NI; i++) cycle(1'b1, W'(i + 1), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("post_reset_frame", fd_a[1], seq_frame);
    step();

    // Randomized traffic with toggling pipe_ena and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(3) != 0, W'($urandom), $urandom_range(5) == 0,
              $urandom_range(9) < 7);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
